// File: rtl/scan_sweep_pkg.sv
// Shared types and defaults for the DDS scan-frequency sweep controller.
// Holds the FSM state enum and default parameter values.
package scan_sweep_pkg;

    localparam int FTW_W_DEF    = 32;
    localparam int CTRL_W_DEF   = 8;
    localparam int STEP_W_DEF   = 12;
    localparam int DWELL_W_DEF  = 16;
    localparam int WCLK_DIV_DEF = 2;
    localparam int RST_CYC_DEF  = 8;
    localparam int DDS_WORD_W   = FTW_W_DEF + CTRL_W_DEF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRST,
        S_LOAD,
        S_FQUD,
        S_DWELL,
        S_DONE
    } state_t;

endpackage

// File: rtl/dds_serial_tx.sv
// Serial DDS word shifter with W_CLK divider; also times the FQ_UD pulse.
// Ports: clk/rst_n, i_load+i_fqud+i_word start a job, i_abort kills it,
// o_last marks the final cycle of a job, o_wclk/o_data/o_fqud drive pins.
module dds_serial_tx #(
    parameter int W        = 40,
    parameter int WCLK_DIV = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_fqud,
    input  logic         i_abort,
    input  logic [W-1:0] i_word,
    output logic         o_last,
    output logic         o_wclk,
    output logic         o_data,
    output logic         o_fqud
);

    localparam int DIV_W = (WCLK_DIV > 1) ? $clog2(WCLK_DIV) : 1;
    localparam int BIT_W = $clog2(W + 1);

    logic             r_active;
    logic             r_fq;
    logic             r_phase;
    logic [DIV_W-1:0] r_div;
    logic [BIT_W-1:0] r_bit;
    logic [W-1:0]     r_sh;
    logic             w_div_end;
    logic             w_bit_end;

    assign w_div_end = (r_div == DIV_W'(WCLK_DIV - 1));
    assign w_bit_end = (r_bit == BIT_W'(W - 1));

    // Final cycle: end of FQ_UD pulse, or end of the last bit's high phase
    assign o_last = r_active & w_div_end & (r_fq | (r_phase & w_bit_end));
    assign o_wclk = r_active & ~r_fq & r_phase;
    assign o_data = r_active & ~r_fq & r_sh[0];
    assign o_fqud = r_active & r_fq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_fq     <= 1'b0;
            r_phase  <= 1'b0;
            r_div    <= '0;
            r_bit    <= '0;
            r_sh     <= '0;
        end else if (i_abort) begin
            r_active <= 1'b0;
            r_phase  <= 1'b0;
            r_div    <= '0;
        end else if (i_load) begin
            r_active <= 1'b1;
            r_fq     <= i_fqud;
            r_sh     <= i_word;
            r_bit    <= '0;
            r_div    <= '0;
            r_phase  <= 1'b0;
        end else if (r_active) begin
            if (w_div_end) begin
                r_div <= '0;
                if (r_fq) begin
                    r_active <= 1'b0;
                end else if (!r_phase) begin
                    r_phase <= 1'b1;
                end else begin
                    // Data changes only as W_CLK falls
                    r_phase <= 1'b0;
                    r_sh    <= r_sh >> 1;
                    r_bit   <= r_bit + BIT_W'(1);
                    if (w_bit_end) r_active <= 1'b0;
                end
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/scan_freq_sweep.sv
// DDS scan-frequency sweep controller: reset DDS, then per point load word,
// strobe FQ_UD, gate acquisition for the dwell. Optional SCAN_SWEEP_TRIANGLE_EN
// adds mode_tri for an up-then-down sweep. Ports: CLKA/NSYSRESET, start/abort,
// sweep setup inputs, DDS pins, acq_gate, busy, step_idx, scanover.
module scan_freq_sweep
    import scan_sweep_pkg::*;
#(
    parameter int FTW_W    = FTW_W_DEF,
    parameter int CTRL_W   = CTRL_W_DEF,
    parameter int STEP_W   = STEP_W_DEF,
    parameter int DWELL_W  = DWELL_W_DEF,
    parameter int WCLK_DIV = WCLK_DIV_DEF,
    parameter int RST_CYC  = RST_CYC_DEF
) (
    input  logic               CLKA,
    input  logic               NSYSRESET,
    input  logic               start,
    input  logic               abort,
    input  logic [FTW_W-1:0]   f_start,
    input  logic [FTW_W-1:0]   f_step,
    input  logic [STEP_W-1:0]  n_steps,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [CTRL_W-1:0]  ctrl_byte,
`ifdef SCAN_SWEEP_TRIANGLE_EN
    input  logic               mode_tri,
`endif
    output logic               ddsreset,
    output logic               ddswclk,
    output logic               ddsdata,
    output logic               ddsfqud,
    output logic               acq_gate,
    output logic               busy,
    output logic [STEP_W-1:0]  step_idx,
    output logic               scanover
);

    localparam int WORD_W = FTW_W + CTRL_W;

    state_t              r_state;
    state_t              w_state_nx;
    logic [31:0]         r_cnt;
    logic [FTW_W-1:0]    r_acc;
    logic [FTW_W-1:0]    r_step;
    logic [STEP_W-1:0]   r_nsteps;
    logic [STEP_W-1:0]   r_idx;
    logic [DWELL_W-1:0]  r_dwell;
    logic [CTRL_W-1:0]   r_ctrl;
    logic                r_dir;
    logic                w_tri;
    logic                w_turn;
    logic                w_down;
    logic                w_final;
    logic                w_dwell_last;
    logic [31:0]         w_dwell_eff;
    logic [FTW_W-1:0]    w_acc_nx;
    logic [STEP_W-1:0]   w_idx_nx;
    logic                w_advance;
    logic                w_tx_load;
    logic                w_tx_fq;
    logic                w_tx_abort;
    logic                w_tx_last;
    logic [WORD_W-1:0]   w_tx_word;

`ifdef SCAN_SWEEP_TRIANGLE_EN
    logic r_tri;
    assign w_tri = r_tri;
    always_ff @(posedge CLKA or negedge NSYSRESET) begin
        if (!NSYSRESET)
            r_tri <= 1'b0;
        else if (r_state == S_IDLE && start)
            r_tri <= mode_tri;
    end
`else
    assign w_tri = 1'b0;
`endif

    // Next-point decision; a triangle turn reuses the down step
    assign w_turn  = w_tri & ~r_dir & (r_idx == r_nsteps) & (r_nsteps != '0);
    assign w_down  = r_dir | w_turn;
    assign w_final = r_dir ? (r_idx == '0) : ((r_idx == r_nsteps) & ~w_turn);
    assign w_acc_nx = w_down ? (r_acc - r_step) : (r_acc + r_step);
    assign w_idx_nx = w_down ? (r_idx - STEP_W'(1)) : (r_idx + STEP_W'(1));

    assign w_dwell_eff  = (r_dwell == '0) ? 32'd1 : 32'(r_dwell);
    assign w_dwell_last = (r_cnt == w_dwell_eff - 32'd1);

    always_comb begin
        w_state_nx = r_state;
        w_tx_load  = 1'b0;
        w_tx_fq    = 1'b0;
        w_tx_word  = {r_ctrl, r_acc};
        w_advance  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_state_nx = S_DRST;
            end
            S_DRST: begin
                if (abort) begin
                    w_state_nx = S_DONE;
                end else if (r_cnt == 32'(RST_CYC - 1)) begin
                    w_state_nx = S_LOAD;
                    w_tx_load  = 1'b1;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    w_state_nx = S_DONE;
                end else if (w_tx_last) begin
                    w_state_nx = S_FQUD;
                    w_tx_load  = 1'b1;
                    w_tx_fq    = 1'b1;
                end
            end
            S_FQUD: begin
                if (abort)
                    w_state_nx = S_DONE;
                else if (w_tx_last)
                    w_state_nx = S_DWELL;
            end
            S_DWELL: begin
                if (abort) begin
                    w_state_nx = S_DONE;
                end else if (w_dwell_last) begin
                    if (w_final) begin
                        w_state_nx = S_DONE;
                    end else begin
                        w_state_nx = S_LOAD;
                        w_tx_load  = 1'b1;
                        w_tx_word  = {r_ctrl, w_acc_nx};
                        w_advance  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLKA or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_step   <= '0;
            r_nsteps <= '0;
            r_idx    <= '0;
            r_dwell  <= '0;
            r_ctrl   <= '0;
            r_dir    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            if (w_state_nx != r_state)
                r_cnt <= '0;
            else if (r_state == S_DRST || r_state == S_DWELL)
                r_cnt <= r_cnt + 32'd1;
            if (r_state == S_IDLE && start) begin
                r_acc    <= f_start;
                r_step   <= f_step;
                r_nsteps <= n_steps;
                r_dwell  <= dwell;
                r_ctrl   <= ctrl_byte;
                r_idx    <= '0;
                r_dir    <= 1'b0;
            end else if (w_advance) begin
                r_acc <= w_acc_nx;
                r_idx <= w_idx_nx;
                r_dir <= w_down;
            end
        end
    end

    assign w_tx_abort = abort & busy;

    dds_serial_tx #(
        .W        (WORD_W),
        .WCLK_DIV (WCLK_DIV)
    ) u_tx (
        .clk     (CLKA),
        .rst_n   (NSYSRESET),
        .i_load  (w_tx_load),
        .i_fqud  (w_tx_fq),
        .i_abort (w_tx_abort),
        .i_word  (w_tx_word),
        .o_last  (w_tx_last),
        .o_wclk  (ddswclk),
        .o_data  (ddsdata),
        .o_fqud  (ddsfqud)
    );

    assign ddsreset = (r_state == S_DRST);
    assign acq_gate = (r_state == S_DWELL);
    assign busy     = (r_state == S_DRST) | (r_state == S_LOAD) |
                      (r_state == S_FQUD) | (r_state == S_DWELL);
    assign scanover = (r_state == S_DONE);
    assign step_idx = r_idx;

endmodule
